onehot_tx: RTL
==============

# onehot_tx

Serial transmitter that accepts a one-hot select word over a valid/ready handshake, encodes it to a binary index, and shifts a fixed-length frame out on a single line. It is the encoding/transmit end of the one-hot command path; the receive side decodes the index back into one-hot selects. Illegal input words (zero bits or several bits set) are encoded through an explicit default arm: they are always transmitted, never dropped, and they raise an error flag in the frame.

## Interface
- N, default 8: width of the one-hot input; legal range N >= 2.
- IDX_W, default $clog2(N): width of the transmitted index; derived, never overridden.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  the input word is valid.
- in_ready  output  1  the block can accept a word; high only in IDLE.
- in_onehot  input  N  select word; bit k set means index k.
- tx_line  output  1  serial output; 0 when idle.
- tx_busy  output  1  high while a frame is being sent.
- err_count  output  8  saturating count of illegal words accepted.

## Operation
- FSM states: IDLE, START, DATA, FLAG.
- IDLE: in_ready=1, tx_line=0, tx_busy=0. A handshake (in_valid && in_ready at a rising edge) does three things:
  - latches the encoded index into the IDX_W shift register;
  - latches the flag;
  - moves the FSM to START.
- Encoding: exactly one bit k set gives index=k, flag=0. Any other pattern (all-zero or multi-hot) gives index=0, flag=1; this is the explicit default arm. The encoder never holds its previous value, and the FSM case statement has an explicit default that goes to IDLE.
- START: tx_line=1 for one cycle, then DATA.
- DATA: tx_line = shift register bit 0, LSB first. A bit counter runs 0..IDX_W-1. Move to FLAG after bit IDX_W-1.
- FLAG: tx_line=flag for one cycle, then IDLE.
- err_count: increments on each handshake with flag=1 and saturates at 255, with no wrap.
- in_ready=0 and tx_busy=1 in START, DATA and FLAG. in_valid during a frame is ignored. The source must hold in_onehot until a handshake occurs.
- Reset (async, any state, including mid-frame): FSM returns to IDLE; shift register, counter and flag clear. The partial frame is abandoned.
- Output values during reset: in_ready=1, tx_line=0, tx_busy=0, err_count=0.

## Timing
- All outputs are registered or decoded from the registered state only. There is no combinational path from in_valid or in_onehot to any output.
- Handshake at edge E0:
  - START (tx_line=1) in the cycle after E0;
  - data bit i in cycle i+2 after E0;
  - flag in cycle IDX_W+2;
  - IDLE (in_ready=1) from cycle IDX_W+3.
- Frame length is IDX_W+2 cycles. Maximum throughput is one word per IDX_W+3 cycles.
- With N=8, the frame is 5 cycles (start, b0, b1, b2, flag). The earliest next handshake is at E0+6.
- err_count updates at the handshake edge E0.
- Reset deassertion: the first handshake is possible on the first rising edge with rst low.

## Test plan
- N=8, in_onehot=8'b0010_0000 held with in_valid=1 → tx_line sequence 1,1,0,1,0 (start, index 5 LSB-first, flag 0); in_ready low for 5 cycles; err_count stays 0.
- in_onehot=8'b0000_0000 → 1,0,0,0,1; err_count=1. Then in_onehot=8'b1000_0001 → 1,0,0,0,1; err_count=2.
- Back-to-back: in_valid held high across 8'b0000_0001 then 8'b1000_0000 → two frames 1,0,0,0,0 and 1,1,1,1,0, separated by exactly one idle cycle with tx_line=0.
- rst asserted during the second DATA cycle → outputs go to reset values immediately, without waiting for a clock edge. After release, a new word with index 3 gives 1,1,1,0,0 with no residue from the aborted frame.
- 260 illegal words → err_count=255 and holds there; every frame still carries flag=1.
- in_valid raised mid-frame with a new word → it is not accepted until IDLE; the word transmitted is the one present at the next IDLE handshake.

Source files
------------

// File: rtl/onehot_tx.sv
// onehot_tx: one-hot command transmitter.
//   Accepts a one-hot select word over a valid/ready handshake, encodes it to
//   a binary index and sends a frame on a single line:
//     start (1), index bits LSB first (IDX_W cycles), error flag (1 cycle).
//   Words that are not exactly one-hot are still sent, with index 0 and the
//   flag set, and are counted in a saturating 8-bit error counter.
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   input word valid
//   in_ready   block can accept a word (IDLE only)
//   in_onehot  N-bit select word
//   tx_line    serial output, 0 when idle
//   tx_busy    frame in progress
//   err_count  saturating count of illegal words accepted
module onehot_tx #(
   parameter int unsigned N = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] in_onehot,
   output logic         tx_line,
   output logic         tx_busy,
   output logic [7:0]   err_count
);

   localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;
   localparam int unsigned CNT_W = $clog2(IDX_W + 1);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(IDX_W - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      FLAG  = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   sh_q, sh_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               flag_q, flag_d;
   logic [7:0]         err_q, err_d;

   logic [IDX_W-1:0]   enc_idx;
   logic [IDX_W-1:0]   enc_pos;
   logic               enc_flag;
   int unsigned        ones;
   logic               hs;

   // Encoder: count set bits and remember the position of the last one seen.
   // Only a single set bit yields a real index; everything else takes the
   // default arm (index 0, flag 1).
   always_comb begin
      ones    = 0;
      enc_pos = '0;
      for (int unsigned i = 0; i < N; i++) begin
         if (in_onehot[i]) begin
            ones    = ones + 1;
            enc_pos = IDX_W'(i);
         end
      end
      enc_idx  = '0;
      enc_flag = 1'b1;
      case (ones)
         1: begin
            enc_idx  = enc_pos;
            enc_flag = 1'b0;
         end
         default: begin
            enc_idx  = '0;
            enc_flag = 1'b1;
         end
      endcase
   end

   assign hs = in_valid && (state_q == IDLE);

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state and outputs, decoded from registered state only
   always_comb begin
      state_d  = state_q;
      in_ready = 1'b0;
      tx_busy  = 1'b1;
      tx_line  = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            tx_busy  = 1'b0;
            if (in_valid) begin
               state_d = START;
            end
         end
         START: begin
            tx_line = 1'b1;
            state_d = DATA;
         end
         DATA: begin
            tx_line = sh_q[0];
            if (cnt_q == LAST_BIT) begin
               state_d = FLAG;
            end
         end
         FLAG: begin
            tx_line = flag_q;
            state_d = IDLE;
         end
         default: begin
            in_ready = 1'b0;
            tx_busy  = 1'b0;
            tx_line  = 1'b0;
            state_d  = IDLE;
         end
      endcase
   end

   // Datapath next state
   always_comb begin
      sh_d   = sh_q;
      cnt_d  = cnt_q;
      flag_d = flag_q;
      err_d  = err_q;
      if (hs) begin
         sh_d   = enc_idx;
         cnt_d  = '0;
         flag_d = enc_flag;
         if (enc_flag && (err_q != 8'hFF)) begin
            err_d = err_q + 8'd1;
         end
      end else if (state_q == DATA) begin
         sh_d  = sh_q >> 1;
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sh_q   <= '0;
         cnt_q  <= '0;
         flag_q <= 1'b0;
         err_q  <= '0;
      end else begin
         sh_q   <= sh_d;
         cnt_q  <= cnt_d;
         flag_q <= flag_d;
         err_q  <= err_d;
      end
   end

   assign err_count = err_q;

endmodule
